// File: rtl/stmc_pair_packer.sv
// stmc_pair_packer: buffers 16-bit halfwords in a small circular FIFO and
// packs them into 32-bit words for the STMC halfword splitter. Each output
// word carries a 2-bit code: 11 = pair, 10 = lone halfword closing a burst,
// 01 = lone halfword released by the idle timeout, 00 = idle.
//
// Handshake: a halfword moves on the input when in_valid_i && in_ready_o
// are both high at a rising edge; in_ready_o depends only on registered
// state. The output side has no ready; out_stall_i simply forbids pops, and
// a non-zero out_ctl_o is a one-cycle strobe the splitter must consume.
module stmc_pair_packer #(
  parameter int DEPTH         = 8,
  parameter int FLUSH_TIMEOUT = 15,
  parameter int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [15:0]      in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  input  logic             out_stall_i,
  output logic [1:0]       out_ctl_o,
  output logic [31:0]      out_data_o,
  output logic [CNT_W-1:0] fill_level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  localparam logic [1:0] CTL_IDLE = 2'b00;
  localparam logic [1:0] CTL_TMO  = 2'b01;
  localparam logic [1:0] CTL_LAST = 2'b10;
  localparam logic [1:0] CTL_PAIR = 2'b11;

  // Storage and registered state
  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             flush_q, flush_d;
  logic [1:0]       ctl_q, ctl_d;
  logic [31:0]      data_q, data_d;

  // Combinational helpers
  logic             push;
  logic [1:0]       pop_cnt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic             one_stored;
  logic             timer_hit;

  assign in_ready_o   = (count_q < CNT_W'(DEPTH));
  assign push         = in_valid_i && in_ready_o;
  assign rd_ptr_nxt   = rd_ptr_q + PTR_W'(1);
  assign one_stored   = (count_q == CNT_W'(1));
  assign timer_hit    = (FLUSH_TIMEOUT != 0) && (timer_q == TMR_W'(FLUSH_TIMEOUT));

  assign out_ctl_o    = ctl_q;
  assign out_data_o   = data_q;
  assign fill_level_o = count_q;

  // Pop decision and packing of the next output word (stall > pair > last > timeout)
  always_comb begin
    pop_cnt = 2'd0;
    ctl_d   = CTL_IDLE;
    data_d  = 32'h0;
    if (out_stall_i) begin
      pop_cnt = 2'd0;
    end else if (count_q >= CNT_W'(2)) begin
      pop_cnt = 2'd2;
      ctl_d   = CTL_PAIR;
      data_d  = {mem_q[rd_ptr_nxt], mem_q[rd_ptr_q]};
    end else if (one_stored && flush_q) begin
      pop_cnt = 2'd1;
      ctl_d   = CTL_LAST;
      data_d  = {16'h0, mem_q[rd_ptr_q]};
    end else if (one_stored && timer_hit) begin
      pop_cnt = 2'd1;
      ctl_d   = CTL_TMO;
      data_d  = {16'h0, mem_q[rd_ptr_q]};
    end
  end

  // Pointer, fill count, idle timer and burst-flush bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop_cnt);
    timer_d  = timer_q;
    flush_d  = flush_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    // Timer only runs while exactly one halfword waits untouched; a stall
    // freezes it so a held-off halfword does not time out early.
    if (push || (pop_cnt != 2'd0) || !one_stored) begin
      timer_d = '0;
    end else if (out_stall_i) begin
      timer_d = timer_q;
    end else if (!timer_hit && (FLUSH_TIMEOUT != 0)) begin
      timer_d = timer_q + TMR_W'(1);
    end

    // Set wins over clear so a new burst end is never lost.
    if (push && in_last_i) begin
      flush_d = 1'b1;
    end else if ((pop_cnt != 2'd0) && (count_q == CNT_W'(pop_cnt)) && !push) begin
      flush_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      flush_q  <= 1'b0;
      ctl_q    <= CTL_IDLE;
      data_q   <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      flush_q  <= flush_d;
      ctl_q    <= ctl_d;
      data_q   <= data_d;
    end
  end

  // FIFO storage write; contents need no reset since the count guards reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_stmc_pair_packer.sv
// Testbench for stmc_pair_packer: table of pair vectors plus hand-written
// sequences for timeout, burst flush, full/stall, async reset and streaming.
module tb_stmc_pair_packer;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Clock / reset
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = 16'h0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             out_stall = 1'b0;
  logic [1:0]       out_ctl;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] fill_level;

  always #5 clk = ~clk;

  stmc_pair_packer #(.DEPTH(DEPTH), .FLUSH_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .out_stall_i (out_stall),
    .out_ctl_o   (out_ctl),
    .out_data_o  (out_data),
    .fill_level_o(fill_level)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last_b;
    logic [1:0]  exp_ctl;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [4];
  logic [15:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample and drive #1 after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard: compare any emitted word against the expected halfword queue
  task automatic sb_sample(output int words);
    logic [15:0] lo, hi;
    words = 0;
    if (out_ctl == 2'b11) begin
      words = 1;
      if (exp_q.size() < 2) begin
        check("sb_pair_underflow", 32'(exp_q.size()), 32'd2);
      end else begin
        lo = exp_q.pop_front();
        hi = exp_q.pop_front();
        check("sb_pair_data", out_data, {hi, lo});
      end
    end else if (out_ctl != 2'b00) begin
      words = 1;
      if (exp_q.size() < 1) begin
        check("sb_single_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        lo = exp_q.pop_front();
        check("sb_single_data", out_data, {16'h0, lo});
      end
    end
  endtask

  initial begin : main
    int cnt;
    int words;
    int pairs;
    bit seen;

    vecs[0] = '{a: 16'h1111, b: 16'h2222, last_b: 1'b0, exp_ctl: 2'b11, exp_data: 32'h2222_1111};
    vecs[1] = '{a: 16'h0000, b: 16'hFFFF, last_b: 1'b0, exp_ctl: 2'b11, exp_data: 32'hFFFF_0000};
    vecs[2] = '{a: 16'hBEEF, b: 16'hCAFE, last_b: 1'b1, exp_ctl: 2'b11, exp_data: 32'hCAFE_BEEF};
    vecs[3] = '{a: 16'hA5A5, b: 16'h5A5A, last_b: 1'b0, exp_ctl: 2'b11, exp_data: 32'h5A5A_A5A5};

    // Reset state
    #12;
    check("rst_ctl", 32'(out_ctl), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table-driven pairs
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].a, 1'b0);
      push(vecs[i].b, vecs[i].last_b);
      check("pair_fill2", 32'(fill_level), 32'd2);
      check("pair_ctl_pre", 32'(out_ctl), 32'd0);
      tick();
      check("pair_ctl", 32'(out_ctl), 32'(vecs[i].exp_ctl));
      check("pair_data", out_data, vecs[i].exp_data);
      tick();
      check("pair_ctl_after", 32'(out_ctl), 32'd0);
      check("pair_fill0", 32'(fill_level), 32'd0);
    end

    // Lone halfword released by timeout after 16 edges
    push(16'h00AB, 1'b0);
    cnt  = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      cnt++;
      if (out_ctl != 2'b00) seen = 1;
    end
    check("tmo_seen", 32'(seen), 32'd1);
    check("tmo_cycles", 32'(cnt), 32'd16);
    check("tmo_ctl", 32'(out_ctl), 32'd1);
    check("tmo_data", out_data, 32'h0000_00AB);
    check("tmo_fill", 32'(fill_level), 32'd0);
    tick();
    check("tmo_ctl_after", 32'(out_ctl), 32'd0);

    // Burst of three with in_last on the third
    push(16'h0001, 1'b0);
    push(16'h0002, 1'b0);
    push(16'h0003, 1'b1);
    check("last_pair_ctl", 32'(out_ctl), 32'd3);
    check("last_pair_data", out_data, 32'h0002_0001);
    check("last_fill1", 32'(fill_level), 32'd1);
    tick();
    check("last_ctl", 32'(out_ctl), 32'd2);
    check("last_data", out_data, 32'h0000_0003);
    check("last_fill0", 32'(fill_level), 32'd0);
    // flush_pending must be clear: a new lone halfword waits for the timeout
    push(16'h0077, 1'b0);
    tick();
    check("flush_cleared_ctl", 32'(out_ctl), 32'd0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (out_ctl != 2'b00) seen = 1;
    end
    check("drain77_seen", 32'(seen), 32'd1);
    check("drain77_data", out_data, 32'h0000_0077);

    // Fill to DEPTH under stall, refuse a 9th, then drain with wrap-around
    out_stall = 1'b1;
    for (int i = 0; i < 8; i++) push(16'h4000 + 16'(i), 1'b0);
    check("full_fill", 32'(fill_level), 32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_ctl", 32'(out_ctl), 32'd0);
    push(16'hDEAD, 1'b0);
    check("full_no_accept", 32'(fill_level), 32'd8);
    out_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) check("ready_after_pop", 32'(in_ready), 32'd1);
      check("drain_ctl", 32'(out_ctl), 32'd3);
      check("drain_data", out_data, {16'h4000 + 16'(2*k+1), 16'h4000 + 16'(2*k)});
    end
    tick();
    check("drain_idle", 32'(out_ctl), 32'd0);
    check("drain_fill0", 32'(fill_level), 32'd0);

    // Asynchronous reset mid-stream with fill_level = 5
    out_stall = 1'b1;
    for (int i = 0; i < 7; i++) push(16'h6000 + 16'(i), 1'b0);
    out_stall = 1'b0;
    tick();
    check("pre_rst_ctl", 32'(out_ctl), 32'd3);
    check("pre_rst_data", out_data, 32'h6001_6000);
    check("pre_rst_fill", 32'(fill_level), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ctl", 32'(out_ctl), 32'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_fill", 32'(fill_level), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    tick();
    #2;
    rst = 1'b0;
    tick();
    push(16'h5551, 1'b0);
    push(16'h5552, 1'b0);
    tick();
    check("post_rst_ctl", 32'(out_ctl), 32'd3);
    check("post_rst_data", out_data, 32'h5552_5551);
    tick();
    check("post_rst_fill", 32'(fill_level), 32'd0);

    // Streaming: push every cycle, scoreboard every emitted word
    pairs = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h7000 + 16'(i * 3);
      in_last  = (i == 39);
      exp_q.push_back(in_data);
      tick();
      sb_sample(words);
      if (words != 0) begin
        pairs++;
        check("stream_ctl11", 32'(out_ctl), 32'd3);
      end
      check("stream_fill_le3", 32'(fill_level <= 3), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      sb_sample(words);
      if (words != 0) begin
        pairs++;
        check("stream_ctl11", 32'(out_ctl), 32'd3);
      end
    end
    check("stream_words", 32'(pairs), 32'd20);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    check("stream_fill0", 32'(fill_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stmc_pair_packer.md
Name: stmc_pair_packer

Overview:
Upstream feeder for the STMC halfword splitter stage. It buffers a stream of 16-bit halfwords in a small FIFO and packs them into 32-bit words. For each word it generates the matching 2-bit control code: 11 for a pair, 01/10 for a lone halfword, 00 for idle. The splitter downstream consumes one packed word per cycle whenever the code is non-zero.

Parameters:
DEPTH, 8, FIFO depth in halfwords; power of two, minimum 4.
FLUSH_TIMEOUT, 15, idle cycles after which a lone halfword is emitted; 0 disables the timeout.
CNT_W, $clog2(DEPTH)+1, width of the fill counter.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  in_data is valid this cycle.
in_data  input  16  halfword to enqueue.
in_last  input  1  marks the final halfword of a burst; qualified by in_valid.
in_ready  output  1  FIFO can accept a halfword this cycle.
out_stall  input  1  downstream hold; no pop is allowed while high.
out_ctl  output  2  registered control code for the splitter.
out_data  output  32  registered packed word.
fill_level  output  CNT_W  halfwords currently stored.

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-burst:
  - read pointer, write pointer and fill_level go to 0.
  - timer and flush_pending go to 0.
  - out_ctl goes to 00 and out_data to 0.
  - FIFO contents are discarded; in_ready is 1 immediately after reset.
- Push:
  - in_ready = (fill_level < DEPTH), derived combinationally from the registered count.
  - A halfword is accepted when in_valid && in_ready, written at wr_ptr; pointer wraps modulo DEPTH.
  - in_valid while in_ready=0: no write, no state change; the source must hold the data.
- Pop decision, evaluated every cycle on the start-of-cycle fill_level (a halfword pushed this cycle is not eligible until the next cycle):
  - P0, out_stall=1: no pop; out_ctl<=00, out_data<=0.
  - P2, fill_level>=2: pop two. out_data[15:0]<=older entry, out_data[31:16]<=newer entry, out_ctl<=11.
  - P1L, fill_level==1 and flush_pending: pop one. out_data<={16'h0, entry}, out_ctl<=10.
  - P1T, fill_level==1, FLUSH_TIMEOUT!=0 and timer==FLUSH_TIMEOUT: pop one. out_data<={16'h0, entry}, out_ctl<=01.
  - Otherwise: out_ctl<=00, out_data<=0.
  - Priority order is P0 > P2 > P1L > P1T.
- Outputs are registered: a pop in cycle N appears on out_ctl/out_data after edge N. Each non-zero code lasts exactly one cycle unless the next cycle also pops.
- fill_level next value = fill_level + push - pops; simultaneous push and pop are both honoured. Reaching DEPTH or 0 exactly is legal.
- Timer (width sized to FLUSH_TIMEOUT):
  - Increments, saturating at FLUSH_TIMEOUT, while fill_level==1, no push, no pop and out_stall=0.
  - Cleared on any accepted push, any pop, or fill_level!=1.
  - Frozen while out_stall=1.
- flush_pending:
  - Set on an accepted push with in_last=1.
  - Cleared in the cycle whose pops bring fill_level to 0 with no concurrent push.
  - A push with in_last in the same cycle as that clearing leaves it set (set wins).
- Burst boundaries are not enforced: P2 may pair the last halfword of one burst with the first of the next if both are already stored.
- A lone halfword with FLUSH_TIMEOUT=0 and no in_last stays stored indefinitely.

Test Plan:
- Reset then push A=0x1111, B=0x2222 back-to-back, no stall -> one cycle with out_ctl=11, out_data=0x22221111; fill_level returns to 0; out_ctl=00 afterwards.
- Push a single 0x00AB, no last, FLUSH_TIMEOUT=15 -> out_ctl stays 00 while the timer counts to 15; then one cycle with out_ctl=01, out_data=0x000000AB.
- Push 0x0001, 0x0002, 0x0003 with in_last on the third -> out_ctl=11 with 0x00020001, then out_ctl=10 with 0x00000003; flush_pending cleared.
- Hold out_stall=1 and push 8 halfwords -> in_ready drops to 0 at fill_level=8 and a 9th in_valid is not accepted. Release the stall -> four consecutive 11 words in FIFO order, in_ready returns to 1 after the first pop, and pointer wrap-around is exercised.
- Assert rst mid-stream with fill_level=5 -> all outputs 0 within the same cycle, without waiting for a clock edge. After release, new pushes pack correctly with no stale data.
- Push on every cycle with no stall -> steady alternating push/pop; fill_level stays at or below 3; every emitted word is 11; no halfword lost or duplicated (check with a scoreboard).
